nibble_link_scheduler: RTL and testbench
========================================

NIBBLE_LINK_SCHEDULER -- requirements
Module: nibble_link_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning maximum outstanding read transactions (power of two, >= 2).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning word-address width.
REQ-003 SHALL have port clk  input  1  clock; all flops rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports inst_q_valid/inst_q_ready  input/output  1/1  instruction request handshake; inst_q_addr  input  ADDR_W  read address.
REQ-006 SHALL have ports data_q_valid/data_q_ready  input/output  1/1  LSU request handshake; data_q_addr  input  ADDR_W; data_q_write  input  1; data_q_wdata  input  32; data_q_strb  input  4.
REQ-007 SHALL have ports link_q_valid  output  1, link_q_ready  input  1, link_q_req  output  mem_req_t (addr, wdata, strb, write); request to nibble serializer.
REQ-008 SHALL have ports link_p_valid  input  1, link_p_ready  output  1, link_p_data  input  32; read response from nibble deserializer.
REQ-009 SHALL have ports inst_p_valid  output  1, inst_p_ready  input  1, data_p_valid  output  1, data_p_ready  input  1, p_data  output  32 (shared by both).
REQ-010 SHALL have ports outstanding  output  $clog2(DEPTH)+1  read count; rsp_err  output  1  sticky orphan-response flag.

Function
REQ-011 SHALL hold requests in one output register (link_q_valid, link_q_req); register loads when empty or link_q_ready=1 same cycle; latency request-accept to link_q_valid = 1 cycle.
REQ-012 SHALL arbitrate round-robin: pointer rr starts at INST; on simultaneous eligible requests pick rr side; after any grant rr points to the other side.
REQ-013 SHALL treat a requester as eligible only if valid=1 and (write=1 or outstanding < DEPTH); instruction requests are always reads.
REQ-014 SHALL assert at most one of inst_q_ready/data_q_ready per cycle, only when output register can load; ready never depends on the non-selected side.
REQ-015 SHALL, on accepting a read, push its target ID (INST/DATA) into the in-order target FIFO same cycle; writes push nothing and expect no response.
REQ-016 SHALL, at outstanding == DEPTH, block reads even if a pop occurs that cycle (no link_p->ready combinational path); writes remain grantable.
REQ-017 SHALL route link_p to head-ID port: that port's p_valid = link_p_valid & !empty; link_p_ready = selected port's p_ready & !empty; other port's p_valid = 0.
REQ-018 SHALL pop the FIFO on link_p_valid & link_p_ready; simultaneous push and pop leave outstanding unchanged.
REQ-019 SHALL, on link_p_valid with FIFO empty, hold link_p_ready=0 and set rsp_err=1 next cycle, cleared only by reset.
REQ-020 SHALL keep link_q_req stable while link_q_valid=1 and link_q_ready=0 (AXI-style).
REQ-021 SHALL drive p_data = link_p_data combinationally.

Reset
REQ-022 SHALL, while rst_n=0, force link_q_valid=0, link_q_req=0, outstanding=0, rsp_err=0, rr=INST, FIFO empty; all ready/p_valid outputs 0.
REQ-023 SHALL discard in-flight requests and pending IDs on reset mid-operation; first post-reset grant follows REQ-012 from rr=INST.

Structure
REQ-024 SHALL take mem_req_t and target_e {INST=0, DATA=1} from shared package heichips_link_pkg.
REQ-025 SHALL instantiate one sub-module link_id_fifo (1-bit wide, DEPTH entries, wrap-around pointers, count output) for target IDs.

Verification
REQ-026 Both valid at reset-exit, read addrs 0x10 (inst)/0x20 (data), link_q_ready=1 -> link_q 0x10 then 0x20 on consecutive cycles; IDs INST,DATA.
REQ-027 Four data reads 0x01..0x04, no response -> outstanding=4; fifth read stalled; data write 0x05 wdata 0xDEADBEEF strb 0xF granted.
REQ-028 Inst read then data read, responses 0xAAAA5555, 0x12345678 -> first on inst_p, second on data_p; outstanding 2->0.
REQ-029 link_q_ready=0 for 5 cycles with pending request -> link_q_req unchanged; other requester's ready stays 0.
REQ-030 link_p_valid=1 with FIFO empty -> link_p_ready=0, rsp_err=1 next cycle and sticky.
REQ-031 rst_n low with 3 outstanding and link_q_valid=1 -> all outputs reset immediately; post-reset response ignored and flags rsp_err.

Source files
------------

// File: rtl/heichips_link_pkg.sv
// heichips_link_pkg: request record and response-target IDs shared by the nibble link blocks
package heichips_link_pkg;
  localparam int LINK_ADDR_W = 32;
  typedef enum logic {INST = 1'b0, DATA = 1'b1} target_e;
  typedef struct packed {
    logic [LINK_ADDR_W-1:0] addr;
    logic [31:0]            wdata;
    logic [3:0]             strb;
    logic                   write;
  } mem_req_t;
endpackage

// File: rtl/link_id_fifo.sv
// link_id_fifo: in-order 1-bit target-ID queue with wrap-around pointers and occupancy count
module link_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     din,
  input  logic                     pop,
  output logic                     dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d    = wr_q + PW'(push);
    rd_d    = rd_q + PW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
    dout    = mem_q[rd_q];
    empty   = count_q == '0;
    count   = count_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/nibble_link_scheduler.sv
// nibble_link_scheduler: round-robin merge of instruction and LSU requests onto one nibble link,
// with in-order routing of read responses back to their requester
module nibble_link_scheduler
  import heichips_link_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inst_q_valid,
  output logic                   inst_q_ready,
  input  logic [ADDR_W-1:0]      inst_q_addr,
  input  logic                   data_q_valid,
  output logic                   data_q_ready,
  input  logic [ADDR_W-1:0]      data_q_addr,
  input  logic                   data_q_write,
  input  logic [31:0]            data_q_wdata,
  input  logic [3:0]             data_q_strb,
  output logic                   link_q_valid,
  input  logic                   link_q_ready,
  output mem_req_t               link_q_req,
  input  logic                   link_p_valid,
  output logic                   link_p_ready,
  input  logic [31:0]            link_p_data,
  output logic                   inst_p_valid,
  input  logic                   inst_p_ready,
  output logic                   data_p_valid,
  input  logic                   data_p_ready,
  output logic [31:0]            p_data,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   rsp_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic     link_q_valid_q, link_q_valid_d, rsp_err_q, rsp_err_d;
  mem_req_t req_q, req_d;
  target_e  rr_q, rr_d;
  logic     can_load, rd_ok, inst_elig, data_elig, grant_inst, grant_data;
  logic     push, pop, empty, head_bit;
  link_id_fifo #(.DEPTH(DEPTH)) u_ids (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (grant_data),
    .pop   (pop),
    .dout  (head_bit),
    .empty (empty),
    .count (outstanding)
  );
  // Read limit uses the registered count only, so link_p never reaches the request readies
  always_comb begin
    can_load       = rst_n & (!link_q_valid_q | link_q_ready);
    rd_ok          = outstanding < CW'(DEPTH);
    inst_elig      = inst_q_valid & rd_ok;
    data_elig      = data_q_valid & (data_q_write | rd_ok);
    grant_inst     = can_load & inst_elig & (!data_elig | rr_q == INST);
    grant_data     = can_load & data_elig & (!inst_elig | rr_q == DATA);
    inst_q_ready   = grant_inst;
    data_q_ready   = grant_data;
    push           = grant_inst | (grant_data & !data_q_write);
    inst_p_valid   = link_p_valid & !empty & (target_e'(head_bit) == INST);
    data_p_valid   = link_p_valid & !empty & (target_e'(head_bit) == DATA);
    link_p_ready   = !empty & (target_e'(head_bit) == INST ? inst_p_ready : data_p_ready);
    pop            = link_p_valid & link_p_ready;
    p_data         = link_p_data;
    rsp_err_d      = rsp_err_q | (link_p_valid & empty);
    rr_d           = grant_inst ? DATA : grant_data ? INST : rr_q;
    link_q_valid_d = grant_inst | grant_data | (link_q_valid_q & !link_q_ready);
    req_d          = grant_inst ? mem_req_t'{addr: LINK_ADDR_W'(inst_q_addr), wdata: '0, strb: '0, write: 1'b0}
                   : grant_data ? mem_req_t'{addr: LINK_ADDR_W'(data_q_addr), wdata: data_q_wdata,
                                             strb: data_q_strb, write: data_q_write}
                   : req_q;
    link_q_valid   = link_q_valid_q;
    link_q_req     = req_q;
    rsp_err        = rsp_err_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_q_valid_q <= 1'b0;
      req_q          <= '0;
      rr_q           <= INST;
      rsp_err_q      <= 1'b0;
    end else begin
      link_q_valid_q <= link_q_valid_d;
      req_q          <= req_d;
      rr_q           <= rr_d;
      rsp_err_q      <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_nibble_link_scheduler.sv
// tb_nibble_link_scheduler: table-driven arbitration vectors plus directed multi-cycle sequences
module tb_nibble_link_scheduler;
  import heichips_link_pkg::*;
  logic clk, rst_n;
  logic inst_q_valid, inst_q_ready;
  logic [7:0] inst_q_addr;
  logic data_q_valid, data_q_ready, data_q_write;
  logic [7:0] data_q_addr;
  logic [31:0] data_q_wdata;
  logic [3:0] data_q_strb;
  logic link_q_valid, link_q_ready;
  mem_req_t link_q_req;
  logic link_p_valid, link_p_ready;
  logic [31:0] link_p_data;
  logic inst_p_valid, inst_p_ready, data_p_valid, data_p_ready;
  logic [31:0] p_data;
  logic [2:0] outstanding;
  logic rsp_err;
  int n_vec = 0;
  int n_miss = 0;

  nibble_link_scheduler #(.DEPTH(4), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_q_valid(inst_q_valid), .inst_q_ready(inst_q_ready), .inst_q_addr(inst_q_addr),
    .data_q_valid(data_q_valid), .data_q_ready(data_q_ready), .data_q_addr(data_q_addr),
    .data_q_write(data_q_write), .data_q_wdata(data_q_wdata), .data_q_strb(data_q_strb),
    .link_q_valid(link_q_valid), .link_q_ready(link_q_ready), .link_q_req(link_q_req),
    .link_p_valid(link_p_valid), .link_p_ready(link_p_ready), .link_p_data(link_p_data),
    .inst_p_valid(inst_p_valid), .inst_p_ready(inst_p_ready),
    .data_p_valid(data_p_valid), .data_p_ready(data_p_ready),
    .p_data(p_data), .outstanding(outstanding), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] ia;
    logic       dv;
    logic       dw;
    logic [7:0] da;
    logic       lqr;
    logic       ir;
    logic       dr;
    logic       lqv;
    logic [7:0] addr;
    logic [2:0] out;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    inst_q_valid = 1'b0;
    data_q_valid = 1'b0;
    data_q_write = 1'b0;
    link_p_valid = 1'b0;
    link_q_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'h30, 1'b1, 1'b0, 8'h40, 1'b1, 1'b1, 1'b0, 1'b1, 8'h30, 3'd1};
    tbl[1] = '{1'b1, 8'h30, 1'b1, 1'b0, 8'h40, 1'b1, 1'b0, 1'b1, 1'b1, 8'h40, 3'd2};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0, 1'b1, 1'b1, 8'h41, 3'd2};
    tbl[3] = '{1'b1, 8'h31, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41, 3'd2};
    tbl[4] = '{1'b1, 8'h31, 1'b1, 1'b0, 8'h42, 1'b1, 1'b1, 1'b0, 1'b1, 8'h31, 3'd3};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd3};
    tbl[6] = '{1'b1, 8'h32, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h32, 3'd4};
    tbl[7] = '{1'b1, 8'h33, 1'b1, 1'b0, 8'h43, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd4};
    tbl[8] = '{1'b1, 8'h33, 1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 3'd4};
    rst_n = 1'b0;
    inst_q_valid = 1'b1; inst_q_addr = 8'h10;
    data_q_valid = 1'b1; data_q_addr = 8'h20; data_q_write = 1'b0;
    data_q_wdata = 32'h0; data_q_strb = 4'h0;
    link_q_ready = 1'b1;
    link_p_valid = 1'b0; link_p_data = 32'h0;
    inst_p_ready = 1'b0; data_p_ready = 1'b0;
    #1;
    chk("rst_inst_q_ready", inst_q_ready, 0);
    chk("rst_data_q_ready", data_q_ready, 0);
    chk("rst_link_q_valid", link_q_valid, 0);
    chk("rst_link_q_req", link_q_req, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_rsp_err", rsp_err, 0);
    tick();
    tick();
    // both requesters valid at reset exit: INST first, then DATA
    rst_n = 1'b1;
    #3;
    chk("exit_inst_ready", inst_q_ready, 1);
    chk("exit_data_ready", data_q_ready, 0);
    tick();
    chk("exit_q1_valid", link_q_valid, 1);
    chk("exit_q1_addr", link_q_req.addr, 32'h10);
    inst_q_valid = 1'b0;
    #3;
    chk("exit_data_ready2", data_q_ready, 1);
    tick();
    chk("exit_q2_addr", link_q_req.addr, 32'h20);
    chk("exit_q2_write", link_q_req.write, 0);
    chk("exit_outstanding", outstanding, 2);
    data_q_valid = 1'b0;
    // responses route by ID order; head INST blocks on inst_p_ready
    link_p_valid = 1'b1; link_p_data = 32'hAAAA5555;
    inst_p_ready = 1'b0; data_p_ready = 1'b1;
    #3;
    chk("rsp1_hold_link_p_ready", link_p_ready, 0);
    chk("rsp1_hold_inst_p_valid", inst_p_valid, 1);
    tick();
    chk("rsp1_hold_outstanding", outstanding, 2);
    inst_p_ready = 1'b1;
    #3;
    chk("rsp1_inst_p_valid", inst_p_valid, 1);
    chk("rsp1_data_p_valid", data_p_valid, 0);
    chk("rsp1_p_data", p_data, 32'hAAAA5555);
    chk("rsp1_link_p_ready", link_p_ready, 1);
    tick();
    chk("rsp1_outstanding", outstanding, 1);
    link_p_data = 32'h12345678;
    #3;
    chk("rsp2_inst_p_valid", inst_p_valid, 0);
    chk("rsp2_data_p_valid", data_p_valid, 1);
    chk("rsp2_p_data", p_data, 32'h12345678);
    tick();
    chk("rsp2_outstanding", outstanding, 0);
    link_p_valid = 1'b0;
    chk("rsp_no_err", rsp_err, 0);

    do_reset();
    for (int i = 0; i < 9; i++) begin
      inst_q_valid = tbl[i].iv; inst_q_addr = tbl[i].ia;
      data_q_valid = tbl[i].dv; data_q_write = tbl[i].dw; data_q_addr = tbl[i].da;
      link_q_ready = tbl[i].lqr;
      #3;
      chk($sformatf("v%0d_inst_q_ready", i), inst_q_ready, tbl[i].ir);
      chk($sformatf("v%0d_data_q_ready", i), data_q_ready, tbl[i].dr);
      tick();
      chk($sformatf("v%0d_link_q_valid", i), link_q_valid, tbl[i].lqv);
      if (tbl[i].lqv) chk($sformatf("v%0d_addr", i), link_q_req.addr, 32'(tbl[i].addr));
      chk($sformatf("v%0d_outstanding", i), outstanding, tbl[i].out);
    end

    // four reads fill the ID queue; fifth read stalls, a write still passes
    do_reset();
    data_q_valid = 1'b1; data_q_write = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      data_q_addr = 8'(k);
      #3;
      chk($sformatf("fill%0d_data_ready", k), data_q_ready, 1);
      tick();
    end
    chk("fill_outstanding", outstanding, 4);
    data_q_addr = 8'h05;
    #3;
    chk("fill_read5_ready", data_q_ready, 0);
    tick();
    chk("fill_read5_outstanding", outstanding, 4);
    data_q_write = 1'b1; data_q_wdata = 32'hDEADBEEF; data_q_strb = 4'hF;
    #3;
    chk("fill_write_ready", data_q_ready, 1);
    tick();
    chk("fill_write_addr", link_q_req.addr, 32'h05);
    chk("fill_write_wdata", link_q_req.wdata, 32'hDEADBEEF);
    chk("fill_write_strb", link_q_req.strb, 4'hF);
    chk("fill_write_flag", link_q_req.write, 1);
    chk("fill_write_outstanding", outstanding, 4);
    data_q_valid = 1'b0;

    // back-pressure holds the request and starves the other side
    do_reset();
    link_q_ready = 1'b0;
    inst_q_valid = 1'b1; inst_q_addr = 8'h50;
    #3;
    chk("bp_inst_ready", inst_q_ready, 1);
    tick();
    inst_q_valid = 1'b0;
    data_q_valid = 1'b1; data_q_write = 1'b1; data_q_addr = 8'h60;
    data_q_wdata = 32'h1; data_q_strb = 4'h1;
    for (int k = 0; k < 5; k++) begin
      #3;
      chk($sformatf("bp%0d_data_ready", k), data_q_ready, 0);
      tick();
      chk($sformatf("bp%0d_valid", k), link_q_valid, 1);
      chk($sformatf("bp%0d_addr", k), link_q_req.addr, 32'h50);
    end
    link_q_ready = 1'b1;
    #3;
    chk("bp_release_data_ready", data_q_ready, 1);
    tick();
    chk("bp_release_addr", link_q_req.addr, 32'h60);
    data_q_valid = 1'b0;

    // orphan response
    do_reset();
    link_p_valid = 1'b1; inst_p_ready = 1'b1; data_p_ready = 1'b1;
    #3;
    chk("orphan_link_p_ready", link_p_ready, 0);
    chk("orphan_inst_p_valid", inst_p_valid, 0);
    chk("orphan_data_p_valid", data_p_valid, 0);
    chk("orphan_err_before", rsp_err, 0);
    tick();
    chk("orphan_err_set", rsp_err, 1);
    link_p_valid = 1'b0;
    tick();
    tick();
    chk("orphan_err_sticky", rsp_err, 1);

    // reset mid-operation
    do_reset();
    chk("orphan_err_cleared", rsp_err, 0);
    inst_q_valid = 1'b1; inst_q_addr = 8'h70;
    tick();
    tick();
    tick();
    chk("mid_outstanding", outstanding, 3);
    chk("mid_valid", link_q_valid, 1);
    inst_q_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", link_q_valid, 0);
    chk("mid_rst_req", link_q_req, 0);
    chk("mid_rst_outstanding", outstanding, 0);
    chk("mid_rst_err", rsp_err, 0);
    tick();
    rst_n = 1'b1;
    link_p_valid = 1'b1;
    #3;
    chk("mid_post_link_p_ready", link_p_ready, 0);
    chk("mid_post_inst_p_valid", inst_p_valid, 0);
    tick();
    chk("mid_post_err", rsp_err, 1);
    link_p_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
